// File: rtl/hdmi_packet_parser.sv
// Reassembles byte-serial HDMI data-island packets into header + 4 subpackets, checks InfoFrames.
// Optional saturating statistics counters are enabled by defining PARSER_STATS_EN.
module hdmi_packet_parser #(
  parameter int MAX_IF_LENGTH = 27,
  parameter int STAT_WIDTH    = 16
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic [7:0]            in_byte,
  output logic [23:0]           header,
  output logic [3:0][55:0]      sub,
  output logic                  pkt_valid,
  output logic                  pkt_err,
  output logic [1:0]            err_code,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] good_count,
  output logic [STAT_WIDTH-1:0] bad_count
);

  typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_t;

  localparam logic [4:0] MAX_LEN = 5'(MAX_IF_LENGTH);

  state_t           state_reg, state_next;
  logic [4:0]       idx_reg, idx_next;
  logic [2:0][7:0]  hb_reg, hb_next;
  logic [27:0][7:0] pb_reg, pb_next;
  logic [7:0]       sum_reg, sum_next;
  logic             good_reg, good_next;
  logic [1:0]       code_reg, code_next;
  logic [23:0]      header_reg;
  logic [3:0][55:0] sub_reg, sub_load;
  logic             start, abort, last_byte, in_pkt;
  logic [4:0]       len;

  assign start     = in_valid & in_sop;
  assign in_pkt    = (state_reg == HDR) || (state_reg == BODY);
  assign abort     = start & in_pkt & ~reset;
  assign last_byte = (state_reg == BODY) & in_valid & ~in_sop & (idx_reg == 5'd27);
  assign len       = hb_reg[2][4:0];

  // State register
  always_ff @(posedge clk_pixel) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; DONE behaves like IDLE so packets may run back-to-back
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: state_next = start ? HDR : IDLE;
      HDR: begin
        if (start)                         state_next = HDR;
        else if (in_valid && idx_reg[0])   state_next = BODY;
      end
      BODY: begin
        if (start)          state_next = HDR;
        else if (last_byte) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture datapath and running checksum
  always_comb begin
    idx_next  = idx_reg;
    hb_next   = hb_reg;
    pb_next   = pb_reg;
    sum_next  = sum_reg;
    good_next = good_reg;
    code_next = code_reg;
    if (start) begin
      hb_next[0] = in_byte;
      idx_next   = 5'd0;
      sum_next   = in_byte;
    end else if (in_valid) begin
      if (state_reg == HDR) begin
        if (idx_reg[0]) hb_next[2] = in_byte;
        else            hb_next[1] = in_byte;
        idx_next = idx_reg[0] ? 5'd0 : 5'd1;
        sum_next = sum_reg + in_byte;
      end else if (state_reg == BODY) begin
        pb_next[idx_reg] = in_byte;
        idx_next         = idx_reg + 5'd1;
        if (idx_reg <= len) sum_next = sum_reg + in_byte;
      end
    end
    if (last_byte) begin
      // Length error outranks checksum error; non-InfoFrames are never checked
      if (hb_reg[0][7] && (len > MAX_LEN)) begin
        good_next = 1'b0;
        code_next = 2'd2;
      end else if (hb_reg[0][7] && (sum_next != 8'd0)) begin
        good_next = 1'b0;
        code_next = 2'd1;
      end else begin
        good_next = 1'b1;
        code_next = 2'd0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_load[gi] = pb_next[7*gi +: 7];
    end
  endgenerate

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      idx_reg    <= '0;
      hb_reg     <= '0;
      pb_reg     <= '0;
      sum_reg    <= '0;
      good_reg   <= 1'b0;
      code_reg   <= 2'd0;
      header_reg <= '0;
      sub_reg    <= '0;
    end else begin
      idx_reg  <= idx_next;
      hb_reg   <= hb_next;
      pb_reg   <= pb_next;
      sum_reg  <= sum_next;
      good_reg <= good_next;
      code_reg <= code_next;
      if (last_byte && good_next) begin
        header_reg <= {hb_reg[2], hb_reg[1], hb_reg[0]};
        sub_reg    <= sub_load;
      end
    end
  end

  // Output logic; abort is combinational so it lines up with the new HB0 byte
  always_comb begin
    busy      = in_pkt;
    pkt_valid = (state_reg == DONE) & good_reg & ~reset;
    pkt_err   = ((state_reg == DONE) & ~good_reg & ~reset) | abort;
    err_code  = 2'd0;
    if (abort)                                           err_code = 2'd3;
    else if ((state_reg == DONE) && !good_reg && !reset) err_code = code_reg;
  end

  assign header = header_reg;
  assign sub    = sub_reg;

`ifdef PARSER_STATS_EN
  logic [STAT_WIDTH-1:0] good_cnt_reg, bad_cnt_reg;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
    end else begin
      if (pkt_valid && !(&good_cnt_reg)) good_cnt_reg <= good_cnt_reg + 1'b1;
      if (pkt_err && !(&bad_cnt_reg))    bad_cnt_reg  <= bad_cnt_reg + 1'b1;
    end
  end

  assign good_count = good_cnt_reg;
  assign bad_count  = bad_cnt_reg;
`else
  assign good_count = '0;
  assign bad_count  = '0;
`endif

endmodule

// File: tb/tb_hdmi_packet_parser.sv
// Scoreboard bench for hdmi_packet_parser: directed packets, expected strobes queued and checked by a monitor.
module tb_hdmi_packet_parser;

  logic             clk_pixel = 1'b0;
  logic             reset     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_sop    = 1'b0;
  logic [7:0]       in_byte   = 8'h00;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic             pkt_valid, pkt_err, busy;
  logic [1:0]       err_code;
  logic [15:0]      good_count, bad_count;

  hdmi_packet_parser #(.MAX_IF_LENGTH(27), .STAT_WIDTH(16)) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_byte   (in_byte),
    .header    (header),
    .sub       (sub),
    .pkt_valid (pkt_valid),
    .pkt_err   (pkt_err),
    .err_code  (err_code),
    .busy      (busy),
    .good_count(good_count),
    .bad_count (bad_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  int cycle = 0;
  always @(posedge clk_pixel) cycle <= cycle + 1;

  typedef struct {
    bit               is_err;
    logic [1:0]       code;
    int               cyc;
    logic [23:0]      hdr;
    logic [3:0][55:0] sb;
  } exp_t;

  exp_t             q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               last_cyc = 0;
  logic [23:0]      exp_hdr  = '0;
  logic [3:0][55:0] exp_sub  = '0;
  logic [7:0]       pb_buf [28];
  logic [15:0]      exp_good, exp_bad;

  localparam logic [23:0]      HDR_EXT = 24'h00c07f;
  localparam logic [3:0][55:0] SUB_EXT = {56'h0, 56'h0000000000bf00,
                                          56'h00000000000143, 56'h04000100010084};
  localparam logic [23:0]      HDR_IF  = 24'h0d0282;
  localparam logic [3:0][55:0] SUB_IF  = {56'h0, 56'h0, 56'h0, 56'h0000000000006f};

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cycle);
    end else begin
      $display("ok   %s = %0h (cycle %0d)", name, act, cycle);
    end
  endtask

  // Monitor: pops one expectation per strobe
  always @(negedge clk_pixel) begin
    exp_t e;
    if (pkt_valid && pkt_err) chk("strobe_exclusive", 224'(1), 224'(0));
    if (pkt_valid || pkt_err) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", 224'({pkt_valid, pkt_err}), 224'(0));
      end else begin
        e = q.pop_front();
        chk("strobe_kind", 224'(pkt_err), 224'(e.is_err));
        chk("err_code", 224'(err_code), e.is_err ? 224'(e.code) : 224'(0));
        chk("latency", 224'(cycle), 224'(e.cyc));
        chk("header", 224'(header), 224'(e.hdr));
        chk("sub", 224'(sub), 224'(e.sb));
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic sop);
    @(posedge clk_pixel); #1;
    in_valid = 1'b1;
    in_sop   = sop;
    in_byte  = b;
    last_cyc = cycle;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pixel); #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
    end
  endtask

  task automatic send_rest(input logic [7:0] h1, input logic [7:0] h2, input bit gaps);
    drive(h1, 1'b0);
    if (gaps) idle_cycles(int'($urandom_range(0, 2)));
    drive(h2, 1'b0);
    for (int i = 0; i < 28; i++) begin
      if (gaps) idle_cycles(int'($urandom_range(0, 2)));
      drive(pb_buf[i], 1'b0);
    end
    idle_cycles(1);
  endtask

  task automatic send_pkt(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2, input bit gaps);
    drive(h0, 1'b1);
    send_rest(h1, h2, gaps);
  endtask

  task automatic expect_good(input logic [23:0] h, input logic [3:0][55:0] s);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'd0; e.cyc = last_cyc + 1; e.hdr = h; e.sb = s;
    q.push_back(e);
    exp_hdr = h;
    exp_sub = s;
  endtask

  task automatic expect_err(input logic [1:0] code, input int cyc);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.cyc = cyc; e.hdr = exp_hdr; e.sb = exp_sub;
    q.push_back(e);
  endtask

  task automatic load_ext;
    pb_buf = '{8'h84, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h04, 8'h43, 8'h01, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hbf, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  endtask

  task automatic load_if(input logic [7:0] pb0);
    for (int i = 0; i < 28; i++) pb_buf[i] = 8'h00;
    pb_buf[0] = pb0;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk_pixel);
    chk({tag, "_busy"}, 224'(busy), 224'(0));
    chk({tag, "_header"}, 224'(header), 224'(0));
    chk({tag, "_sub"}, 224'(sub), 224'(0));
    chk({tag, "_strobes"}, 224'({pkt_valid, pkt_err, err_code}), 224'(0));
    chk({tag, "_counts"}, 224'({good_count, bad_count}), 224'(0));
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(posedge clk_pixel);
    check_idle_outputs("reset");
    @(posedge clk_pixel); #1;
    reset = 1'b0;

    // Extended-metadata packet (PB15=bf lands in byte 1 of sub[2])
    load_ext();
    send_pkt(8'h7f, 8'hc0, 8'h00, 1'b0);
    expect_good(HDR_EXT, SUB_EXT);
    idle_cycles(2);

    // Good InfoFrame: 82+02+0d+6f = 0x100
    load_if(8'h6f);
    send_pkt(8'h82, 8'h02, 8'h0d, 1'b0);
    expect_good(HDR_IF, SUB_IF);
    idle_cycles(2);

    // Bad checksum
    load_if(8'h70);
    send_pkt(8'h82, 8'h02, 8'h0d, 1'b0);
    expect_err(2'd1, last_cyc + 1);
    idle_cycles(2);

    // Length 28 exceeds the InfoFrame limit
    load_if(8'h00);
    send_pkt(8'h82, 8'h02, 8'h1c, 1'b0);
    expect_err(2'd2, last_cyc + 1);
    idle_cycles(2);

    // Abort with gaps, then complete the good InfoFrame from the restarting byte
    drive(8'h7f, 1'b1);
    idle_cycles(int'($urandom_range(1, 3)));
    drive(8'hc0, 1'b0);
    drive(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      drive(8'h11 * 8'(i + 1), 1'b0);
    end
    idle_cycles(2);
    drive(8'h82, 1'b1);
    expect_err(2'd3, last_cyc);
    load_if(8'h6f);
    send_rest(8'h02, 8'h0d, 1'b1);
    expect_good(HDR_IF, SUB_IF);
    idle_cycles(3);

`ifdef PARSER_STATS_EN
    exp_good = 16'd3; exp_bad = 16'd3;
`else
    exp_good = 16'd0; exp_bad = 16'd0;
`endif
    @(negedge clk_pixel);
    chk("good_count_pre_reset", 224'(good_count), 224'(exp_good));
    chk("bad_count_pre_reset", 224'(bad_count), 224'(exp_bad));

    // Reset asserted while PB10 is on the bus
    load_if(8'h6f);
    drive(8'h82, 1'b1);
    drive(8'h02, 1'b0);
    drive(8'h0d, 1'b0);
    for (int i = 0; i < 10; i++) drive(pb_buf[i], 1'b0);
    @(negedge clk_pixel);
    chk("busy_mid_body", 224'(busy), 224'(1));
    @(posedge clk_pixel); #1;
    reset = 1'b1; in_valid = 1'b1; in_sop = 1'b0; in_byte = 8'h00;
    @(posedge clk_pixel); #1;
    reset = 1'b0; in_valid = 1'b0;
    exp_hdr = '0;
    exp_sub = '0;
    check_idle_outputs("mid_reset");

    load_ext();
    send_pkt(8'h7f, 8'hc0, 8'h00, 1'b0);
    expect_good(HDR_EXT, SUB_EXT);
    idle_cycles(3);

`ifdef PARSER_STATS_EN
    exp_good = 16'd1;
`else
    exp_good = 16'd0;
`endif
    @(negedge clk_pixel);
    chk("good_count_post_reset", 224'(good_count), 224'(exp_good));
    chk("bad_count_post_reset", 224'(bad_count), 224'(0));
    chk("pending_expectations", 224'(q.size()), 224'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
